mem_bus_arbiter: RTL

Two-requester arbiter for the CPU memory bus, placed between the bus masters and the address-decode/mux stage. Requester 0 is the CPU and requester 1 is a DMA or secondary master; each has a valid/ready handshake matching the CPU's. The arbiter grants one requester at a time, forwards its request to a single downstream port, and routes the response back. A per-transaction timeout completes any access the decoded target never acknowledges.

---
 rtl/mem_bus_arbiter.sv | 80 ++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester memory bus arbiter with round-robin/fixed priority and access timeout
// Ports: clk, reset_n (sync active-low); m0_*/m1_* requester valid/addr/wdata/wstrb in, rdata/ready out;
// s_* single downstream request out, s_rdata/s_ready in; grant one-hot owner; timeout_err one-cycle pulse.
module mem_bus_arbiter #(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic [1:0]  grant,
  output logic        timeout_err
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  grant_q;
  logic        active, sel, mv, tmo, done, pick1;
  assign active = state_q != IDLE;
  assign sel    = state_q == GNT1;
  assign mv     = sel ? m1_valid : m0_valid;
  // s_ready takes precedence over an expiring counter
  assign tmo    = active && mv && !s_ready && cnt_q == 16'(TIMEOUT - 1);
  assign done   = active && mv && (s_ready || tmo);
  // requester 1 wins when alone, or on a tie under round-robin when requester 0 went last
  assign pick1  = m1_valid && (!m0_valid || (FIXED_PRIO == 0 && !last_q));
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q + 16'd1;
    if (!active) begin
      cnt_d = '0;
      if (m0_valid || m1_valid) begin
        state_d = pick1 ? GNT1 : GNT0;
        last_d  = pick1;
      end
    end else if (!mv || s_ready || tmo) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= state_d == GNT0 ? 2'b01 : state_d == GNT1 ? 2'b10 : 2'b00;
    end
  end
  assign grant       = grant_q;
  assign s_valid     = active;
  assign s_addr      = !active ? '0 : sel ? m1_addr : m0_addr;
  assign s_wdata     = !active ? '0 : sel ? m1_wdata : m0_wdata;
  assign s_wstrb     = !active ? '0 : sel ? m1_wstrb : m0_wstrb;
  assign m0_ready    = done && !sel;
  assign m1_ready    = done && sel;
  assign m0_rdata    = (state_q == GNT0 && !tmo) ? s_rdata : '0;
  assign m1_rdata    = (sel && !tmo) ? s_rdata : '0;
  assign timeout_err = tmo;
endmodule
